// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode map, handshake FSM states
// and the packed status-flag record.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_NEG = 3'b110,
    OP_XOR = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic dz;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative multiply / restoring-divide engine, one step per clock.
// The hi/lo register pair is shared: for MUL hi accumulates the partial
// product while lo shifts out the multiplier; for DIV hi is the partial
// remainder while lo shifts the dividend out and the quotient in.
// done_o flags the cycle in which the final step happens; the result
// outputs show the post-step values so the caller can register them on
// that same edge.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_quot_o,
  output logic [WIDTH-1:0]     rem_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step, lo_step;

  // One shift-add or restoring-subtract step computed from the current registers.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, dvs_q});
    hi_step   = hi_q;
    lo_step   = lo_q;
    if (is_div_q) begin
      hi_step = div_ge ? WIDTH'(div_shift - {1'b0, dvs_q}) : div_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      {hi_step, lo_step} = {mul_sum, lo_q[WIDTH-1:1]};
    end
  end

  // Load operands on start, otherwise step while the counter is non-zero.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      hi_d     = '0;
      lo_d     = a_i;
      dvs_d    = b_i;
      is_div_d = is_div_i;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Engine registers; reset clears the counter so an aborted run never reports done.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done_o      = (cnt_q == CW'(1));
  assign prod_quot_o = is_div_q ? {{WIDTH{1'b0}}, lo_step} : {hi_step, lo_step};
  assign rem_o       = hi_step;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and status flags.
// Single-cycle ops and divide-by-zero complete on the accept edge; MUL and
// DIV run through the iterative engine for WIDTH cycles.
// Optional build macro ALU_SEQ_REM_EN: DIV packs the remainder into the
// upper half of res.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 flag_dz
);

  alu_state_t         state_q, state_d;
  alu_op_t            op_q, op_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  alu_flags_t         flags_q, flags_d;

  alu_op_t            op_in;
  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0] single_res;
  logic               single_carry;
  logic               eng_start, eng_done;
  logic [2*WIDTH-1:0] eng_prod, div_res;
  logic [WIDTH-1:0]   eng_rem;

  assign op_in = alu_op_t'(sel);
  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start_i     (eng_start),
    .is_div_i    (op_in == OP_DIV),
    .a_i         (a),
    .b_i         (b),
    .done_o      (eng_done),
    .prod_quot_o (eng_prod),
    .rem_o       (eng_rem)
  );

`ifdef ALU_SEQ_REM_EN
  assign div_res = {eng_rem, eng_prod[WIDTH-1:0]};
`else
  logic unused_rem;
  assign unused_rem = ^eng_rem;
  assign div_res    = eng_prod;
`endif

  // Single-cycle result and carry straight from the input operands.
  always_comb begin
    single_res   = '0;
    single_carry = 1'b0;
    case (op_in)
      OP_ADD: begin
        single_res   = a_ext + b_ext;
        single_carry = single_res[WIDTH];
      end
      OP_SUB: begin
        single_res   = a_ext - b_ext;
        single_carry = (a < b);
      end
      OP_AND:  single_res = a_ext & b_ext;
      OP_OR:   single_res = a_ext | b_ext;
      OP_XOR:  single_res = a_ext ^ b_ext;
      OP_NEG:  single_res = ~a_ext;
      default: single_res = '0;
    endcase
  end

  // Handshake FSM next state plus result/flag capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    flags_d   = flags_q;
    eng_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op_in;
          if (op_in == OP_MUL || (op_in == OP_DIV && b != '0)) begin
            eng_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            res_d         = single_res;
            flags_d.zero  = (single_res == '0);
            flags_d.carry = single_carry;
            flags_d.dz    = (op_in == OP_DIV);
            state_d       = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (eng_done) begin
          res_d         = (op_q == OP_DIV) ? div_res : eng_prod;
          flags_d.zero  = (res_d == '0);
          flags_d.carry = 1'b0;
          flags_d.dz    = 1'b0;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured opcode, result and flags registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign res        = res_q;
  assign flag_zero  = flags_q.zero;
  assign flag_carry = flags_q.carry;
  assign flag_dz    = flags_q.dz;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed cases, backpressure,
// reset mid-operation, back-to-back handoff and randomized ops against an
// arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic [2:0]     sel;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] res;
  logic           flag_zero, flag_carry, flag_dz;

  int checks = 0;
  int passes = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res        (res),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_dz    (flag_dz)
  );

  always #5 clk = ~clk;

  // Reference model from the arithmetic definition of each opcode.
  function automatic void model(input int op, input int unsigned x, input int unsigned y,
                                output int unsigned r, output bit c, output bit dz,
                                output int lat);
    int unsigned mask;
    mask = (1 << (2 * W)) - 1;
    c = 0; dz = 0; lat = 1;
    case (op)
      0: begin r = x + y; c = (x + y) >= (1 << W); end
      1: begin r = (x - y) & mask; c = (x < y); end
      2: begin r = x * y; lat = W + 1; end
      3: begin
        if (y == 0) begin r = 0; dz = 1; end
        else begin
          r = x / y;
`ifdef ALU_SEQ_REM_EN
          r = r + ((x % y) << W);
`endif
          lat = W + 1;
        end
      end
      4: r = x & y;
      5: r = x | y;
      6: r = (~x) & mask;
      default: r = x ^ y;
    endcase
  endfunction

  // Present one op, wait for out_valid (bounded), report latency and any in_ready seen.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output bit sawReady);
    sel = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    sawReady = in_ready;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) sawReady = 1'b1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, res, flag_zero, flag_carry, flag_dz} !== {1'b0, 1'b1, 16'h0, 3'b000})
      $display("[TB] FAIL reset: got ov=%b ir=%b res=%h flags=%b%b%b want ov=0 ir=1 res=0000 flags=000",
               out_valid, in_ready, res, flag_zero, flag_carry, flag_dz);
    else passes++;
  endtask

  task automatic test_directed();
    int lat; bit sr;
    issue(3'b000, 8'd200, 8'd100, lat, sr);
    checks++;
    if ({lat, res, flag_carry, flag_zero, flag_dz} !== {32'd1, 16'h012C, 3'b100})
      $display("[TB] FAIL add: got lat=%0d res=%h c=%b z=%b dz=%b want lat=1 res=012c c=1 z=0 dz=0",
               lat, res, flag_carry, flag_zero, flag_dz);
    else passes++;
    drain();
    issue(3'b001, 8'd5, 8'd7, lat, sr);
    checks++;
    if ({res, flag_carry} !== {16'hFFFE, 1'b1})
      $display("[TB] FAIL sub: got res=%h c=%b want fffe c=1", res, flag_carry);
    else passes++;
    drain();
    issue(3'b110, 8'h0F, 8'h00, lat, sr);
    checks++;
    if ({res, flag_carry, flag_zero} !== {16'hFFF0, 2'b00})
      $display("[TB] FAIL neg: got res=%h c=%b z=%b want fff0 c=0 z=0", res, flag_carry, flag_zero);
    else passes++;
    drain();
    issue(3'b010, 8'd255, 8'd255, lat, sr);
    checks++;
    if ({lat, sr, res, flag_carry} !== {32'd9, 1'b0, 16'hFE01, 1'b0})
      $display("[TB] FAIL mul: got lat=%0d sawReady=%b res=%h c=%b want lat=9 sawReady=0 res=fe01 c=0",
               lat, sr, res, flag_carry);
    else passes++;
    drain();
    issue(3'b011, 8'd100, 8'd7, lat, sr);
    checks++;
`ifdef ALU_SEQ_REM_EN
    if ({lat, res, flag_dz} !== {32'd9, 16'h020E, 1'b0})
      $display("[TB] FAIL div: got lat=%0d res=%h dz=%b want lat=9 res=020e dz=0", lat, res, flag_dz);
`else
    if ({lat, res, flag_dz} !== {32'd9, 16'h000E, 1'b0})
      $display("[TB] FAIL div: got lat=%0d res=%h dz=%b want lat=9 res=000e dz=0", lat, res, flag_dz);
`endif
    else passes++;
    drain();
    issue(3'b011, 8'd9, 8'd0, lat, sr);
    checks++;
    if ({lat, res, flag_dz, flag_zero, flag_carry} !== {32'd1, 16'h0, 3'b110})
      $display("[TB] FAIL div0: got lat=%0d res=%h dz=%b z=%b c=%b want lat=1 res=0 dz=1 z=1 c=0",
               lat, res, flag_dz, flag_zero, flag_carry);
    else passes++;
    drain();
  endtask

  task automatic test_backpressure();
    int lat; bit sr;
    bit bad = 0;
    issue(3'b000, 8'd1, 8'd1, lat, sr);
    for (int i = 0; i < 3; i++) begin
      if (!(out_valid === 1'b1 && res === 16'h0002 && in_ready === 1'b0)) bad = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad || res !== 16'h0002 || in_ready !== 1'b0)
      $display("[TB] FAIL backpressure_hold: got res=%h ir=%b unstable=%b want res=0002 ir=0 unstable=0",
               res, in_ready, bad);
    else passes++;
    drain();
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("[TB] FAIL backpressure_release: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit sr;
    sel = 3'b010; a = 8'd200; b = 8'd77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, res, in_ready} !== {1'b0, 16'h0, 1'b1})
      $display("[TB] FAIL reset_mid_mul: got ov=%b res=%h ir=%b want ov=0 res=0000 ir=1",
               out_valid, res, in_ready);
    else passes++;
    issue(3'b100, 8'hF0, 8'h3C, lat, sr);
    checks++;
    if ({lat, res} !== {32'd1, 16'h0030})
      $display("[TB] FAIL and_after_reset: got lat=%0d res=%h want lat=1 res=0030", lat, res);
    else passes++;
    drain();
  endtask

  task automatic test_back_to_back();
    int lat; bit sr;
    issue(3'b101, 8'h12, 8'h40, lat, sr);
    sel = 3'b111; a = 8'hAA; b = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 16'h0052})
      $display("[TB] FAIL b2b_exit: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0052", out_valid, in_ready, res);
    else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, res} !== {1'b1, 16'h00A5})
      $display("[TB] FAIL b2b_next: got ov=%b res=%h want ov=1 res=00a5", out_valid, res);
    else passes++;
    drain();
  endtask

  task automatic test_random();
    int lat, expLat; bit sr, expC, expDz;
    int unsigned expR;
    logic [2:0] op; logic [W-1:0] x, y;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = W'($urandom);
      y  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      model(int'(op), int'(x), int'(y), expR, expC, expDz, expLat);
      issue(op, x, y, lat, sr);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      checks++;
      if (lat !== expLat || res !== (2*W)'(expR) || flag_carry !== expC || flag_dz !== expDz ||
          flag_zero !== (expR == 0))
        $display("[TB] FAIL random op=%0d a=%0d b=%0d: got lat=%0d res=%h c=%b dz=%b z=%b want lat=%0d res=%h c=%b dz=%b z=%b",
                 op, x, y, lat, res, flag_carry, flag_dz, flag_zero, expLat, (2*W)'(expR), expC, expDz, expR == 0);
      else passes++;
      drain();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
